alien_fleet: RTL and testbench

Enemy-side game block: owns a ROWS×COLS grid of aliens that marches across the 640×480 playfield, resolves the player bullet against the grid, and returns the one-cycle `bullet_hit` pulse consumed by the player block. It also produces the alien layer pixel colour for the shared `xPixel`/`yPixel` scan, a running score, and the wave-clear and invasion status flags. It sits beside the player block in the game top level. Bullet coordinates come from the player; `bullet_hit` goes back to the player.

---
 rtl/alien_fleet.sv | 266 ++++++++++++++++++++++++++
 tb/tb_alien_fleet.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_fleet.sv
// alien_fleet: enemy-side game block. Owns a ROWS x COLS alien grid that marches across the
// playfield, resolves the player bullet against the grid, draws the alien layer and keeps score.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   bullet_x_i/_y_i  player bullet left/top edge
//   bullet_active_i  player bullet in flight
//   x_pixel_i/_y_i   current scan pixel
//   bullet_hit_o     registered one-cycle hit pulse back to the player
//   alien_color_o    combinational alien-layer colour, 0 when not on a live alien
//   score_o          accumulated points, saturating at 1023
//   wave_clear_o     high while the cleared wave is being held
//   invaded_o        high once the fleet has reached the invasion line (terminal)
module alien_fleet #(
   parameter int unsigned ROWS         = 3,
   parameter int unsigned COLS         = 8,
   parameter int unsigned COL_PITCH    = 64,
   parameter int unsigned ROW_PITCH    = 32,
   parameter int unsigned ALIEN_W      = 48,
   parameter int unsigned ALIEN_H      = 24,
   parameter int unsigned START_X      = 64,
   parameter int unsigned START_Y      = 48,
   parameter int unsigned STEP         = 8,
   parameter int unsigned DROP_STEP    = 16,
   parameter int unsigned MOVE_DELAY   = 5000000,
   parameter int unsigned CLEAR_HOLD   = 50000000,
   parameter int unsigned SCREEN_WIDTH = 640,
   parameter int unsigned INVASION_Y   = 400,
   parameter int unsigned BULLET_WIDTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [9:0]  bullet_x_i,
   input  logic [9:0]  bullet_y_i,
   input  logic        bullet_active_i,
   input  logic [9:0]  x_pixel_i,
   input  logic [9:0]  y_pixel_i,
   output logic        bullet_hit_o,
   output logic [23:0] alien_color_o,
   output logic [9:0]  score_o,
   output logic        wave_clear_o,
   output logic        invaded_o
);

   localparam int unsigned N   = ROWS * COLS;
   localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW  = $clog2(COL_PITCH);
   localparam int unsigned RW  = $clog2(ROW_PITCH);
   localparam int unsigned MCW = $clog2(MOVE_DELAY + 2);
   localparam int unsigned HCW = $clog2(CLEAR_HOLD + 2);

   // 12-bit working width holds every coordinate sum without wrap.
   localparam logic [11:0] FleetW    = 12'(COLS * COL_PITCH);
   localparam logic [11:0] FleetH    = 12'(ROWS * ROW_PITCH);
   localparam logic [11:0] ColMask   = 12'(COL_PITCH - 1);
   localparam logic [11:0] RowMask   = 12'(ROW_PITCH - 1);
   localparam logic [11:0] AlienW    = 12'(ALIEN_W);
   localparam logic [11:0] AlienH    = 12'(ALIEN_H);
   localparam logic [11:0] StepW     = 12'(STEP);
   localparam logic [11:0] ScreenW   = 12'(SCREEN_WIDTH);
   localparam logic [11:0] InvasionY = 12'(INVASION_Y);
   localparam logic [11:0] HalfBullet = 12'(BULLET_WIDTH / 2);

   typedef enum logic [1:0] {StMarch, StCleared, StOver} state_e;

   typedef struct packed {
      logic           valid;  // point lies inside an alien box (alive or not)
      logic [RIW-1:0] row;
      logic [IW-1:0]  idx;
   } cell_t;

   // Shared cell math for the bullet tip and the scan pixel.
   function automatic cell_t locate(input logic [11:0] x, input logic [11:0] y,
                                    input logic [11:0] fx, input logic [11:0] fy);
      cell_t       c;
      logic [11:0] ox, oy, colw, roww;
      logic        in_grid;
      ox      = x - fx;
      oy      = y - fy;
      in_grid = (x >= fx) && (x < fx + FleetW) && (y >= fy) && (y < fy + FleetH);
      colw    = ox >> CW;
      roww    = oy >> RW;
      c.valid = in_grid && ((ox & ColMask) < AlienW) && ((oy & RowMask) < AlienH);
      c.row   = RIW'(roww);
      c.idx   = IW'(roww * 12'(COLS) + colw);
      return c;
   endfunction

   state_e          state_q, state_d;
   logic [9:0]      fleet_x_q, fleet_x_d;
   logic [9:0]      fleet_y_q, fleet_y_d;
   logic            dir_q, dir_d;  // 1 = moving right
   logic [N-1:0]    alive_q, alive_d;
   logic [MCW-1:0]  move_cnt_q, move_cnt_d;
   logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
   logic            lockout_q, lockout_d;
   logic            bullet_hit_q, bullet_hit_d;
   logic [9:0]      score_q, score_d;

   cell_t       tip_cell, pix_cell;
   logic        hit_now;
   logic [9:0]  points;
   logic [10:0] score_sum;
   logic [11:0] fleet_bottom;
   logic        right_blocked, left_blocked;

   assign tip_cell = locate({2'b00, bullet_x_i} + HalfBullet, {2'b00, bullet_y_i},
                            {2'b00, fleet_x_q}, {2'b00, fleet_y_q});
   assign pix_cell = locate({2'b00, x_pixel_i}, {2'b00, y_pixel_i},
                            {2'b00, fleet_x_q}, {2'b00, fleet_y_q});

   assign hit_now = (state_q == StMarch) && bullet_active_i && !lockout_q &&
                    tip_cell.valid && alive_q[tip_cell.idx];

   assign fleet_bottom  = {2'b00, fleet_y_q} + FleetH;
   assign right_blocked = ({2'b00, fleet_x_q} + StepW + FleetW) > ScreenW;
   assign left_blocked  = {2'b00, fleet_x_q} < StepW;

   always_comb begin
      points = 10'd10;
      if (tip_cell.row == RIW'(0)) begin
         points = 10'd30;
      end else if (tip_cell.row == RIW'(1)) begin
         points = 10'd20;
      end
   end

   assign score_sum = {1'b0, score_q} + {1'b0, points};

   // FSM: state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StMarch;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state. An empty grid wins over the invasion check.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StMarch: begin
            if (alive_q == '0) begin
               state_d = StCleared;
            end else if (fleet_bottom >= InvasionY) begin
               state_d = StOver;
            end
         end
         StCleared: begin
            if (hold_cnt_q == '0) begin
               state_d = StMarch;
            end
         end
         StOver:  state_d = StOver;
         default: state_d = StMarch;
      endcase
   end

   // FSM: outputs
   always_comb begin
      wave_clear_o = 1'b0;
      invaded_o    = 1'b0;
      unique case (state_q)
         StCleared: wave_clear_o = 1'b1;
         StOver:    invaded_o    = 1'b1;
         default:   ;
      endcase
   end

   // Datapath next state
   always_comb begin
      fleet_x_d    = fleet_x_q;
      fleet_y_d    = fleet_y_q;
      dir_d        = dir_q;
      alive_d      = alive_q;
      move_cnt_d   = move_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      lockout_d    = lockout_q;
      bullet_hit_d = 1'b0;
      score_d      = score_q;

      if (!bullet_active_i) begin
         lockout_d = 1'b0;
      end

      if (state_q == StMarch) begin
         hold_cnt_d = HCW'(CLEAR_HOLD);
         if (move_cnt_q == '0) begin
            move_cnt_d = MCW'(MOVE_DELAY);
            // An edge event drops and reverses without moving sideways.
            if ((dir_q && right_blocked) || (!dir_q && left_blocked)) begin
               fleet_y_d = fleet_y_q + 10'(DROP_STEP);
               dir_d     = !dir_q;
            end else if (dir_q) begin
               fleet_x_d = fleet_x_q + 10'(STEP);
            end else begin
               fleet_x_d = fleet_x_q - 10'(STEP);
            end
         end else begin
            move_cnt_d = move_cnt_q - 1'b1;
         end

         if (hit_now) begin
            alive_d[tip_cell.idx] = 1'b0;
            bullet_hit_d          = 1'b1;
            lockout_d             = 1'b1;
            score_d               = (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];
         end
      end else if (state_q == StCleared) begin
         if (hold_cnt_q == '0) begin
            fleet_x_d  = 10'(START_X);
            fleet_y_d  = 10'(START_Y);
            dir_d      = 1'b1;
            alive_d    = '1;
            move_cnt_d = MCW'(MOVE_DELAY);
         end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fleet_x_q    <= 10'(START_X);
         fleet_y_q    <= 10'(START_Y);
         dir_q        <= 1'b1;
         alive_q      <= '1;
         move_cnt_q   <= MCW'(MOVE_DELAY);
         hold_cnt_q   <= HCW'(CLEAR_HOLD);
         lockout_q    <= 1'b0;
         bullet_hit_q <= 1'b0;
         score_q      <= '0;
      end else begin
         fleet_x_q    <= fleet_x_d;
         fleet_y_q    <= fleet_y_d;
         dir_q        <= dir_d;
         alive_q      <= alive_d;
         move_cnt_q   <= move_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         lockout_q    <= lockout_d;
         bullet_hit_q <= bullet_hit_d;
         score_q      <= score_d;
      end
   end

   // Alien layer colour; dead aliens are drawn black.
   always_comb begin
      alien_color_o = 24'h000000;
      if (pix_cell.valid && alive_q[pix_cell.idx]) begin
         if (pix_cell.row == RIW'(0)) begin
            alien_color_o = 24'hFF00FF;
         end else if (pix_cell.row == RIW'(1)) begin
            alien_color_o = 24'h00FFFF;
         end else begin
            alien_color_o = 24'hFFFF00;
         end
      end
   end

   assign bullet_hit_o = bullet_hit_q;
   assign score_o      = score_q;

endmodule

// File: tb/tb_alien_fleet.sv
// Bench for alien_fleet with a short march period (200 cycles) and a short clear hold.
module tb_alien_fleet;

   localparam int unsigned MD = 199;
   localparam int unsigned CH = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  bx, by, xp, yp;
   logic        ba;
   logic        hit;
   logic [23:0] color;
   logic [9:0]  score;
   logic        wclr, inv;

   int errors = 0;
   int checks = 0;
   int mx, my;
   bit mdir;

   alien_fleet #(
      .MOVE_DELAY(MD),
      .CLEAR_HOLD(CH)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .bullet_x_i     (bx),
      .bullet_y_i     (by),
      .bullet_active_i(ba),
      .x_pixel_i      (xp),
      .y_pixel_i      (yp),
      .bullet_hit_o   (hit),
      .alien_color_o  (color),
      .score_o        (score),
      .wave_clear_o   (wclr),
      .invaded_o      (inv)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] bx;
      logic [9:0] by;
      logic       act;
      logic       exp_hit;
      logic [9:0] exp_score;
   } hit_vec_t;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [23:0] exp_color;
   } col_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic color_at(input int x, input int y, input logic [23:0] exp, input string nm);
      xp = 10'(x);
      yp = 10'(y);
      #1;
      chk(nm, {8'h00, color}, {8'h00, exp});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ba    = 1'b0;
      bx    = '0;
      by    = '0;
      xp    = '0;
      yp    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mx    = 64;
      my    = 48;
      mdir  = 1'b1;
   endtask

   // Reference march event for a full 8-column fleet on a 640-wide screen.
   task automatic model_event();
      if (mdir) begin
         if (mx + 8 + 512 > 640) begin
            my   = my + 16;
            mdir = 1'b0;
         end else begin
            mx = mx + 8;
         end
      end else begin
         if (mx < 8) begin
            my   = my + 16;
            mdir = 1'b1;
         end else begin
            mx = mx - 8;
         end
      end
   endtask

   hit_vec_t hv[$];
   col_vec_t cv[$];

   initial begin
      int  ones;
      bit  done;
      bit  reached;

      cv.push_back('{10'd64,  10'd48,  24'hFF00FF});
      cv.push_back('{10'd63,  10'd48,  24'h000000});
      cv.push_back('{10'd111, 10'd48,  24'hFF00FF});
      cv.push_back('{10'd112, 10'd48,  24'h000000});
      cv.push_back('{10'd64,  10'd71,  24'hFF00FF});
      cv.push_back('{10'd64,  10'd72,  24'h000000});
      cv.push_back('{10'd64,  10'd80,  24'h00FFFF});
      cv.push_back('{10'd64,  10'd112, 24'hFFFF00});
      cv.push_back('{10'd64,  10'd135, 24'hFFFF00});
      cv.push_back('{10'd64,  10'd136, 24'h000000});
      cv.push_back('{10'd559, 10'd48,  24'hFF00FF});
      cv.push_back('{10'd560, 10'd48,  24'h000000});
      cv.push_back('{10'd64,  10'd144, 24'h000000});

      hv.push_back('{10'd62,  10'd50,  1'b1, 1'b1, 10'd30});
      hv.push_back('{10'd62,  10'd50,  1'b1, 1'b0, 10'd30});
      hv.push_back('{10'd62,  10'd50,  1'b0, 1'b0, 10'd30});
      hv.push_back('{10'd62,  10'd50,  1'b1, 1'b0, 10'd30});
      hv.push_back('{10'd62,  10'd50,  1'b0, 1'b0, 10'd30});
      hv.push_back('{10'd112, 10'd50,  1'b1, 1'b0, 10'd30});
      hv.push_back('{10'd61,  10'd50,  1'b1, 1'b0, 10'd30});
      hv.push_back('{10'd126, 10'd50,  1'b1, 1'b1, 10'd60});
      hv.push_back('{10'd126, 10'd50,  1'b0, 1'b0, 10'd60});
      hv.push_back('{10'd62,  10'd120, 1'b1, 1'b1, 10'd70});
      hv.push_back('{10'd62,  10'd120, 1'b0, 1'b0, 10'd70});
      hv.push_back('{10'd62,  10'd82,  1'b1, 1'b1, 10'd90});
      hv.push_back('{10'd62,  10'd82,  1'b0, 1'b0, 10'd90});
      hv.push_back('{10'd190, 10'd72,  1'b1, 1'b0, 10'd90});
      hv.push_back('{10'd190, 10'd71,  1'b1, 1'b1, 10'd120});
      hv.push_back('{10'd190, 10'd71,  1'b0, 1'b0, 10'd120});
      hv.push_back('{10'd574, 10'd50,  1'b1, 1'b0, 10'd120});
      hv.push_back('{10'd557, 10'd50,  1'b1, 1'b1, 10'd150});
      hv.push_back('{10'd557, 10'd50,  1'b0, 1'b0, 10'd150});

      // Phase 1: reset state, static colour map, hit resolution
      do_reset();
      chk("reset_hit", {31'd0, hit}, 32'd0);
      chk("reset_score", {22'd0, score}, 32'd0);
      chk("reset_wave_clear", {31'd0, wclr}, 32'd0);
      chk("reset_invaded", {31'd0, inv}, 32'd0);
      foreach (cv[i]) color_at(cv[i].x, cv[i].y, cv[i].exp_color, $sformatf("color[%0d]", i));
      foreach (hv[i]) begin
         bx = hv[i].bx;
         by = hv[i].by;
         ba = hv[i].act;
         tick();
         chk($sformatf("hit[%0d]", i), {31'd0, hit}, {31'd0, hv[i].exp_hit});
         chk($sformatf("score[%0d]", i), {22'd0, score}, {22'd0, hv[i].exp_score});
      end
      color_at(64, 48, 24'h000000, "dead_r0c0");
      color_at(64, 80, 24'h000000, "dead_r1c0");
      color_at(256, 48, 24'hFF00FF, "live_r0c3");

      // Phase 2: clear the whole wave, then check hold length and restart
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 8; c++) begin
            bx = 10'(62 + c * 64);
            by = 10'(48 + r * 32);
            ba = 1'b1;
            tick();
            chk($sformatf("kill_r%0dc%0d", r, c), {31'd0, hit}, 32'd1);
            if (!(r == 2 && c == 7)) begin
               ba = 1'b0;
               tick();
            end
         end
      end
      ba = 1'b0;
      chk("clear_not_yet", {31'd0, wclr}, 32'd0);
      chk("kill_all_score", {22'd0, score}, 32'd480);
      ones = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         if (wclr) ones++;
         else if (ones > 0) done = 1'b1;
      end
      chk("wave_clear_len", ones, 32'd6);
      color_at(64, 48, 24'hFF00FF, "respawn_r0");
      color_at(63, 48, 24'h000000, "respawn_left");
      color_at(64, 112, 24'hFFFF00, "respawn_r2");
      chk("score_kept", {22'd0, score}, 32'd480);

      // Phase 3: march timing and right-edge drop
      do_reset();
      repeat (199) tick();
      color_at(64, 48, 24'hFF00FF, "before_move1");
      tick();
      model_event();
      color_at(64, 48, 24'h000000, "move1_old");
      color_at(72, 48, 24'hFF00FF, "move1_new");
      for (int ev = 2; ev <= 10; ev++) begin
         repeat (200) tick();
         model_event();
         if (ev == 2) begin
            color_at(79, 48, 24'h000000, "move2_left");
            color_at(80, 48, 24'hFF00FF, "move2_org");
         end else if (ev == 8) begin
            color_at(127, 48, 24'h000000, "move8_left");
            color_at(128, 48, 24'hFF00FF, "move8_org");
         end else if (ev == 9) begin
            color_at(128, 63, 24'h000000, "drop_above");
            color_at(128, 64, 24'hFF00FF, "drop_org");
            color_at(136, 64, 24'hFF00FF, "drop_no_xmove");
         end else if (ev == 10) begin
            color_at(119, 64, 24'h000000, "left1_left");
            color_at(120, 64, 24'hFF00FF, "left1_org");
         end
      end

      // Phase 4: march down to the invasion line
      reached = 1'b0;
      for (int k = 0; k < 400 && !reached; k++) begin
         repeat (200) tick();
         model_event();
         if (my + 96 >= 400) reached = 1'b1;
      end
      if (!reached) begin
         checks++;
         errors++;
         $display("FAIL invasion_timeout: got no invasion expected invasion");
      end
      chk("invade_pending", {31'd0, inv}, 32'd0);
      tick();
      chk("invaded", {31'd0, inv}, 32'd1);
      color_at(mx, 304, 24'hFF00FF, "over_org");
      color_at(mx, 303, 24'h000000, "over_above");
      repeat (500) tick();
      color_at(mx, 304, 24'hFF00FF, "frozen_org");
      color_at(mx, 303, 24'h000000, "frozen_above");
      bx = 10'(mx + 62);
      by = 10'd306;
      ba = 1'b1;
      tick();
      chk("over_no_hit", {31'd0, hit}, 32'd0);
      tick();
      chk("over_no_hit2", {31'd0, hit}, 32'd0);
      chk("over_score", {22'd0, score}, 32'd0);
      color_at(mx + 64, 304, 24'hFF00FF, "over_alien_alive");
      chk("still_invaded", {31'd0, inv}, 32'd1);

      // Asynchronous reset between clock edges
      ba = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_invaded", {31'd0, inv}, 32'd0);
      color_at(64, 48, 24'hFF00FF, "async_rst_org");
      color_at(63, 48, 24'h000000, "async_rst_left");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("after_rst_invaded", {31'd0, inv}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
